// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: button/switch inputs and sequencer outputs of mode_sequencer.
// The master modport drives the inputs and the slave modport is the sequencer side.
interface mode_sequencer_if;
   logic       key_n;
   logic [3:0] sw_mode;
   logic [3:0] current_state;
   logic [1:0] mode;
   logic       state_tick;
   logic       pattern_tick;
   logic       state_changed;

   modport master (
      output key_n, sw_mode,
      input  current_state, mode, state_tick, pattern_tick, state_changed
   );

   modport slave (
      input  key_n, sw_mode,
      output current_state, mode, state_tick, pattern_tick, state_changed
   );
endinterface

// File: rtl/mode_sequencer.sv
// mode_sequencer: debounced mode button, tick-enable dividers and LED state sequencing.
// Optional MODE_SEQ_BOUNCE_EN makes AUTO mode ping-pong instead of wrapping.
module mode_sequencer #(
   parameter int DIV_STATE   = 5000000,
   parameter int DIV_PATTERN = 2500000,
   parameter int DEBOUNCE    = 100000,
   parameter int NUM_STATES  = 8
) (
   input logic             clock,
   input logic             reset_n,
   mode_sequencer_if.slave bus
);
   localparam int SW = $clog2(DIV_STATE);
   localparam int PW = $clog2(DIV_PATTERN);
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [SW-1:0] ST_LAST  = SW'(DIV_STATE - 1);
   localparam logic [PW-1:0] PT_LAST  = PW'(DIV_PATTERN - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
   localparam logic [3:0]    S_LAST   = 4'(NUM_STATES - 1);

   typedef enum logic [1:0] {MANUAL = 2'd0, AUTO = 2'd1, FREEZE = 2'd2} mode_e;

   logic          sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [SW-1:0] st_cnt_q, st_cnt_d;
   logic [PW-1:0] pat_cnt_q, pat_cnt_d;
   mode_e         mode_q, mode_d;
   logic [3:0]    state_q, state_d;
   logic          state_tick_q, state_tick_d;
   logic          pattern_tick_q, pattern_tick_d;
   logic          state_changed_q, state_changed_d;
   logic          key_press;
   logic [3:0]    sw_sat;
`ifdef MODE_SEQ_BOUNCE_EN
   logic          dir_up_q, dir_up_d;
`endif

   always_comb begin
      sync1_d   = bus.key_n;
      sync2_d   = sync1_q;
      level_d   = level_q;
      deb_cnt_d = '0;
      key_press = 1'b0;
      // counter runs only while the synced key disagrees with the accepted level
      if (sync2_q != level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            level_d   = sync2_q;
            key_press = ~sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
         end
      end

      st_cnt_d     = (st_cnt_q == ST_LAST) ? '0 : st_cnt_q + SW'(1);
      state_tick_d = (st_cnt_q == ST_LAST);

      mode_d = mode_q;
      if (key_press) begin
         case (mode_q)
            MANUAL:  mode_d = AUTO;
            AUTO:    mode_d = FREEZE;
            default: mode_d = MANUAL;
         endcase
      end

      sw_sat  = (bus.sw_mode > S_LAST) ? S_LAST : bus.sw_mode;
      state_d = state_q;
`ifdef MODE_SEQ_BOUNCE_EN
      dir_up_d = dir_up_q;
`endif
      // the tick acts on the mode as updated by a coincident key press
      if (state_tick_q) begin
         case (mode_d)
            MANUAL: state_d = sw_sat;
`ifdef MODE_SEQ_BOUNCE_EN
            AUTO: begin
               if (dir_up_q) begin
                  if (state_q == S_LAST) begin
                     state_d  = state_q - 4'd1;
                     dir_up_d = 1'b0;
                  end else begin
                     state_d = state_q + 4'd1;
                  end
               end else begin
                  if (state_q == 4'd0) begin
                     state_d  = state_q + 4'd1;
                     dir_up_d = 1'b1;
                  end else begin
                     state_d = state_q - 4'd1;
                  end
               end
            end
`else
            AUTO: state_d = (state_q == S_LAST) ? 4'd0 : state_q + 4'd1;
`endif
            default: state_d = state_q;
         endcase
      end
      state_changed_d = state_tick_q && (state_d != state_q);

      pattern_tick_d = 1'b0;
      if (state_changed_q) begin
         pat_cnt_d = '0;
      end else if (pat_cnt_q == PT_LAST) begin
         pat_cnt_d      = '0;
         pattern_tick_d = (mode_q != FREEZE);
      end else begin
         pat_cnt_d = pat_cnt_q + PW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q         <= 1'b1;
         sync2_q         <= 1'b1;
         level_q         <= 1'b1;
         deb_cnt_q       <= '0;
         st_cnt_q        <= '0;
         pat_cnt_q       <= '0;
         mode_q          <= MANUAL;
         state_q         <= '0;
         state_tick_q    <= 1'b0;
         pattern_tick_q  <= 1'b0;
         state_changed_q <= 1'b0;
`ifdef MODE_SEQ_BOUNCE_EN
         dir_up_q        <= 1'b1;
`endif
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         level_q         <= level_d;
         deb_cnt_q       <= deb_cnt_d;
         st_cnt_q        <= st_cnt_d;
         pat_cnt_q       <= pat_cnt_d;
         mode_q          <= mode_d;
         state_q         <= state_d;
         state_tick_q    <= state_tick_d;
         pattern_tick_q  <= pattern_tick_d;
         state_changed_q <= state_changed_d;
`ifdef MODE_SEQ_BOUNCE_EN
         dir_up_q        <= dir_up_d;
`endif
      end
   end

   assign bus.current_state = state_q;
   assign bus.mode          = mode_q;
   assign bus.state_tick    = state_tick_q;
   assign bus.pattern_tick  = pattern_tick_q;
   assign bus.state_changed = state_changed_q;
endmodule
